ofs_fim_axi_mmio_csr_slave: RTL and testbench
=============================================

Name: ofs_fim_axi_mmio_csr_slave

Overview:
- AXI4 MMIO responder. Terminates an MMIO slave port and converts each single-beat read or write into a held request/acknowledge access on a flat CSR bus.
- Sits at the far end of the MMIO pipeline-register chain, in front of feature register files.
- Returns B and R responses with the request ID echoed.
- Bursts are rejected with SLVERR and never reach the CSR bus.

Parameters:
ID_W, 9, AXI ID width (aw/ar/b/r).
ADDR_W, 18, AXI and CSR address width.
DATA_W, 64, data width; WSTRB width is DATA_W/8.
TIMEOUT_CYCLES, 256, ack timeout; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_awvalid/s_awready  in/out  1  AW handshake
s_awid  in  ID_W;  s_awaddr  in  ADDR_W;  s_awlen  in  8
s_wvalid/s_wready  in/out  1;  s_wdata  in  DATA_W;  s_wstrb  in  DATA_W/8;  s_wlast  in  1
s_bvalid/s_bready  out/in  1;  s_bid  out  ID_W;  s_bresp  out  2
s_arvalid/s_arready  in/out  1;  s_arid  in  ID_W;  s_araddr  in  ADDR_W;  s_arlen  in  8
s_rvalid/s_rready  out/in  1;  s_rid  out  ID_W;  s_rdata  out  DATA_W;  s_rresp  out  2;  s_rlast  out  1
csr_wr  out  1  write request, held until csr_ack
csr_rd  out  1  read request, held until csr_ack
csr_addr  out  ADDR_W;  csr_wdata  out  DATA_W;  csr_wstrb  out  DATA_W/8
csr_ack  in  1  one-cycle completion pulse
csr_rdata  in  DATA_W  valid with csr_ack on reads
csr_err  in  1  valid with csr_ack; maps to SLVERR (2'b10)

Behaviour:
- Reset: all valids, csr_wr and csr_rd are 0; awready, wready and arready are 1; bresp, rresp, rdata and rlast are 0; FSM is IDLE; buffers are empty; rr_pri=write.
- Input buffers: one-entry AW, W and AR holding registers. Each ready = buffer empty. A buffer fills on valid&ready and frees when the FSM consumes it. AW and W are accepted independently, in either order.
- FSM states: IDLE, WR_REQ, RD_REQ, WR_DRAIN, RD_ERR, B_RESP, R_RESP.
- IDLE transitions:
  - Write is ready when AW and W are both buffered. Read is ready when AR is buffered.
  - If both are ready, rr_pri picks the winner, and rr_pri toggles after each grant.
  - Write with awlen==0: go to WR_REQ.
  - Write with awlen!=0: go to WR_DRAIN.
  - Read with arlen==0: go to RD_REQ.
  - Read with arlen!=0: go to RD_ERR.
- WR_REQ: csr_wr=1 with addr, data and strb from the buffers. On csr_ack: csr_wr=0 the next cycle, bresp=csr_err?SLVERR:OKAY, go to B_RESP. Minimum latency from IDLE grant to bvalid is 2 cycles when csr_ack arrives in the first request cycle.
- RD_REQ: csr_rd=1. On csr_ack: capture rdata, rresp=csr_err?SLVERR:OKAY, rlast=1, go to R_RESP.
- WR_DRAIN:
  - Consumes W beats (wready=1) until a beat with wlast=1 is accepted. The beat already buffered counts; if it carried wlast, the drain ends immediately.
  - No CSR access. Then bresp=SLVERR, go to B_RESP.
- RD_ERR:
  - Returns arlen+1 beats with rdata=0, rresp=SLVERR and rid=arid.
  - An 8-bit beat counter counts down; rlast=1 on the final beat.
  - Each beat advances on s_rvalid&s_rready. Return to IDLE after the last beat.
- B_RESP / R_RESP: hold valid and payload stable until ready, then free the consumed buffer(s) and return to IDLE. The buffer may refill in that same cycle.
- csr_ack arriving outside WR_REQ/RD_REQ is ignored.
- Only one CSR access is outstanding at any time.
- Reset mid-transaction: the outstanding access is abandoned and csr_wr/csr_rd drop in the following cycle. No response is generated.

Optional Feature:
- Macro: OFS_FIM_MMIO_CSR_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WR_REQ/RD_REQ and increments each cycle without csr_ack.
  - When the counter reaches TIMEOUT_CYCLES, the request drops, rdata=all-ones and the response is SLVERR.
  - A late csr_ack for a timed-out access is ignored.
- Without the macro: no counter exists, and the FSM waits for csr_ack indefinitely.

Test Plan:
- Write awid=5, addr=0x100, data=0xDEAD_BEEF, strb=0xFF, ack on cycle 3 -> one csr_wr access with those values; bid=5, bresp=OKAY.
- Read arid=7, addr=0x40, ack with rdata=0x1234, err=0 -> rid=7, rdata=0x1234, rresp=OKAY, rlast=1; W data presented before AW behaves identically.
- Write AW+W and read AR present in the same cycle, twice -> first grant goes to the write, second to the read; no overlapping csr_wr/csr_rd.
- Read with arlen=3 -> 4 R beats of SLVERR, rlast only on the 4th; write with awlen=2 -> 3 W beats drained, one B with SLVERR, csr_wr never asserted.
- s_bready/s_rready held low for 10 cycles -> bvalid/rvalid and payload stable; no new CSR access starts.
- With OFS_FIM_MMIO_CSR_TIMEOUT_EN and no ack -> SLVERR with rdata=all-ones after 256 cycles; a late ack is ignored. Reset asserted mid-WR_REQ -> csr_wr=0 the next cycle and no bvalid.

Source files
------------

// File: rtl/ofs_fim_axi_mmio_csr_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : ofs_fim_axi_mmio_csr_slave_if
// Description : AXI4 MMIO slave channels plus the flat CSR request/ack bus
//               seen by ofs_fim_axi_mmio_csr_slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface ofs_fim_axi_mmio_csr_slave_if #(
    parameter int ID_W   = 9,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 64
);
    // AXI write address / data / response
    logic                s_awvalid;
    logic                s_awready;
    logic [ID_W-1:0]     s_awid;
    logic [ADDR_W-1:0]   s_awaddr;
    logic [7:0]          s_awlen;
    logic                s_wvalid;
    logic                s_wready;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_wlast;
    logic                s_bvalid;
    logic                s_bready;
    logic [ID_W-1:0]     s_bid;
    logic [1:0]          s_bresp;
    // AXI read address / data
    logic                s_arvalid;
    logic                s_arready;
    logic [ID_W-1:0]     s_arid;
    logic [ADDR_W-1:0]   s_araddr;
    logic [7:0]          s_arlen;
    logic                s_rvalid;
    logic                s_rready;
    logic [ID_W-1:0]     s_rid;
    logic [DATA_W-1:0]   s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rlast;
    // Flat CSR bus
    logic                csr_wr;
    logic                csr_rd;
    logic [ADDR_W-1:0]   csr_addr;
    logic [DATA_W-1:0]   csr_wdata;
    logic [DATA_W/8-1:0] csr_wstrb;
    logic                csr_ack;
    logic [DATA_W-1:0]   csr_rdata;
    logic                csr_err;

    // Upstream MMIO master and downstream register file together
    modport master (
        output s_awvalid, s_awid, s_awaddr, s_awlen,
        input  s_awready,
        output s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_wready,
        input  s_bvalid, s_bid, s_bresp,
        output s_bready,
        output s_arvalid, s_arid, s_araddr, s_arlen,
        input  s_arready,
        input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
        output s_rready,
        input  csr_wr, csr_rd, csr_addr, csr_wdata, csr_wstrb,
        output csr_ack, csr_rdata, csr_err
    );

    // The responder itself
    modport slave (
        input  s_awvalid, s_awid, s_awaddr, s_awlen,
        output s_awready,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_wready,
        output s_bvalid, s_bid, s_bresp,
        input  s_bready,
        input  s_arvalid, s_arid, s_araddr, s_arlen,
        output s_arready,
        output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
        input  s_rready,
        output csr_wr, csr_rd, csr_addr, csr_wdata, csr_wstrb,
        input  csr_ack, csr_rdata, csr_err
    );
endinterface
`default_nettype wire

// File: rtl/ofs_fim_axi_mmio_csr_slave.sv
`default_nettype none
// ============================================================================
// Module      : ofs_fim_axi_mmio_csr_slave
// Description : AXI4 MMIO responder. Single-beat reads/writes become held
//               csr_wr/csr_rd requests released by csr_ack; bursts are
//               answered with SLVERR without touching the CSR bus.
//               Optional macro OFS_FIM_MMIO_CSR_TIMEOUT_EN adds an ack
//               timeout of TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module ofs_fim_axi_mmio_csr_slave #(
    parameter int ID_W           = 9,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input wire clk,
    input wire rst,
    ofs_fim_axi_mmio_csr_slave_if.slave bus
);
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_RD_REQ, S_WR_DRAIN, S_RD_ERR, S_B_RESP, S_R_RESP
    } state_t;

    state_t r_state, w_state_nxt;

    logic                r_aw_full, r_w_full, r_ar_full;
    logic [ID_W-1:0]     r_awid, r_arid;
    logic [ADDR_W-1:0]   r_awaddr, r_araddr;
    logic [7:0]          r_awlen, r_arlen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_wlast;
    logic                r_rr_pri;     // 0: write wins a tie, 1: read wins
    logic [1:0]          r_bresp, r_rresp;
    logic [DATA_W-1:0]   r_rdata;
    logic [7:0]          r_beat_cnt;

    logic w_awready, w_wready, w_arready;
    logic w_free_aw, w_free_w, w_free_ar;
    logic w_bvalid, w_rvalid, w_csr_wr, w_csr_rd;
    logic w_grant_wr, w_grant_rd, w_timeout, w_req_done;
    logic w_aw_fire, w_w_fire, w_ar_fire;

    // Round-robin arbitration between a complete write (AW+W) and a read
    assign w_grant_wr = (r_state == S_IDLE) && r_aw_full && r_w_full &&
                        (!r_ar_full || !r_rr_pri);
    assign w_grant_rd = (r_state == S_IDLE) && r_ar_full && !w_grant_wr;
    assign w_req_done = bus.csr_ack || w_timeout;

`ifdef OFS_FIM_MMIO_CSR_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_to_cnt;
    assign w_timeout = ((r_state == S_WR_REQ) || (r_state == S_RD_REQ)) &&
                       (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES));

    // Ack watchdog: cleared in IDLE so every request starts counting from 0
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_WR_REQ || r_state == S_RD_REQ) &&
                     !bus.csr_ack && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    logic [31:0] w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, handshake readies, buffer release and CSR strobes
    always_comb begin
        w_state_nxt = r_state;
        w_csr_wr    = 1'b0;
        w_csr_rd    = 1'b0;
        w_bvalid    = 1'b0;
        w_rvalid    = 1'b0;
        w_free_aw   = 1'b0;
        w_free_w    = 1'b0;
        w_free_ar   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant_wr)
                    w_state_nxt = (r_awlen == 8'd0) ? S_WR_REQ : S_WR_DRAIN;
                else if (w_grant_rd)
                    w_state_nxt = (r_arlen == 8'd0) ? S_RD_REQ : S_RD_ERR;
            end
            S_WR_REQ: begin
                w_csr_wr = 1'b1;
                if (w_req_done) w_state_nxt = S_B_RESP;
            end
            S_RD_REQ: begin
                w_csr_rd = 1'b1;
                if (w_req_done) w_state_nxt = S_R_RESP;
            end
            S_WR_DRAIN: begin
                // The buffered beat is the first beat; later beats are discarded
                if (r_wlast || (bus.s_wvalid && bus.s_wlast))
                    w_state_nxt = S_B_RESP;
            end
            S_RD_ERR: begin
                w_rvalid = 1'b1;
                if (bus.s_rready && r_beat_cnt == 8'd0) begin
                    w_free_ar   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_B_RESP: begin
                w_bvalid = 1'b1;
                if (bus.s_bready) begin
                    w_free_aw   = 1'b1;
                    w_free_w    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_R_RESP: begin
                w_rvalid = 1'b1;
                if (bus.s_rready) begin
                    w_free_ar   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_awready = !r_aw_full || w_free_aw;
    assign w_arready = !r_ar_full || w_free_ar;
    assign w_wready  = (r_state == S_WR_DRAIN) ? !r_wlast : (!r_w_full || w_free_w);
    assign w_aw_fire = bus.s_awvalid && w_awready;
    assign w_ar_fire = bus.s_arvalid && w_arready;
    assign w_w_fire  = bus.s_wvalid && w_wready && (r_state != S_WR_DRAIN);

    // Buffer occupancy: a fill in the releasing cycle keeps the entry full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_ar_full <= 1'b0;
        end else begin
            if (w_aw_fire)      r_aw_full <= 1'b1;
            else if (w_free_aw) r_aw_full <= 1'b0;
            if (w_w_fire)       r_w_full  <= 1'b1;
            else if (w_free_w)  r_w_full  <= 1'b0;
            if (w_ar_fire)      r_ar_full <= 1'b1;
            else if (w_free_ar) r_ar_full <= 1'b0;
        end
    end

    // Buffer payloads captured on each accepted handshake
    always_ff @(posedge clk) begin
        if (w_aw_fire) begin
            r_awid   <= bus.s_awid;
            r_awaddr <= bus.s_awaddr;
            r_awlen  <= bus.s_awlen;
        end
        if (w_w_fire) begin
            r_wdata <= bus.s_wdata;
            r_wstrb <= bus.s_wstrb;
            r_wlast <= bus.s_wlast;
        end
        if (w_ar_fire) begin
            r_arid   <= bus.s_arid;
            r_araddr <= bus.s_araddr;
            r_arlen  <= bus.s_arlen;
        end
    end

    // Response payloads, arbitration pointer and error-burst beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_pri   <= 1'b0;
            r_bresp    <= c_RESP_OKAY;
            r_rresp    <= c_RESP_OKAY;
            r_rdata    <= '0;
            r_beat_cnt <= 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant_wr) begin
                        r_rr_pri <= ~r_rr_pri;
                        if (r_awlen != 8'd0) r_bresp <= c_RESP_SLVERR;
                    end else if (w_grant_rd) begin
                        r_rr_pri <= ~r_rr_pri;
                        if (r_arlen != 8'd0) begin
                            r_beat_cnt <= r_arlen;
                            r_rdata    <= '0;
                            r_rresp    <= c_RESP_SLVERR;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (bus.csr_ack)
                        r_bresp <= bus.csr_err ? c_RESP_SLVERR : c_RESP_OKAY;
                    else if (w_timeout)
                        r_bresp <= c_RESP_SLVERR;
                end
                S_RD_REQ: begin
                    if (bus.csr_ack) begin
                        r_rdata <= bus.csr_rdata;
                        r_rresp <= bus.csr_err ? c_RESP_SLVERR : c_RESP_OKAY;
                    end else if (w_timeout) begin
                        r_rdata <= '1;
                        r_rresp <= c_RESP_SLVERR;
                    end
                end
                S_RD_ERR: begin
                    if (bus.s_rready && r_beat_cnt != 8'd0)
                        r_beat_cnt <= r_beat_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_awready = w_awready;
    assign bus.s_wready  = w_wready;
    assign bus.s_arready = w_arready;
    assign bus.s_bvalid  = w_bvalid;
    assign bus.s_bid     = r_awid;
    assign bus.s_bresp   = r_bresp;
    assign bus.s_rvalid  = w_rvalid;
    assign bus.s_rid     = r_arid;
    assign bus.s_rdata   = r_rdata;
    assign bus.s_rresp   = r_rresp;
    assign bus.s_rlast   = (r_state == S_R_RESP) ||
                           (r_state == S_RD_ERR && r_beat_cnt == 8'd0);
    assign bus.csr_wr    = w_csr_wr;
    assign bus.csr_rd    = w_csr_rd;
    assign bus.csr_addr  = (r_state == S_RD_REQ) ? r_araddr : r_awaddr;
    assign bus.csr_wdata = r_wdata;
    assign bus.csr_wstrb = r_wstrb;
endmodule
`default_nettype wire

// File: tb/tb_ofs_fim_axi_mmio_csr_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofs_fim_axi_mmio_csr_slave
// Description : Scoreboard bench: directed stimulus pushes expected CSR
//               accesses and B/R responses; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ofs_fim_axi_mmio_csr_slave;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    typedef struct { bit wr; logic [17:0] addr; logic [63:0] data; logic [7:0] strb; } csr_t;
    typedef struct { logic [8:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [8:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ofs_fim_axi_mmio_csr_slave_if #(.ID_W(9), .ADDR_W(18), .DATA_W(64)) bus ();

    ofs_fim_axi_mmio_csr_slave #(
        .ID_W(9), .ADDR_W(18), .DATA_W(64), .TIMEOUT_CYCLES(256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    csr_t q_csr[$];
    b_t   q_b[$];
    r_t   q_r[$];

    bit          ack_en    = 1'b1;
    int          ack_delay = 1;
    logic [63:0] ack_rdata = 64'd0;
    bit          ack_err   = 1'b0;
    bit          late_ack  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic send_aw(input logic [8:0] id, input logic [17:0] addr, input logic [7:0] len);
        int n = 0;
        bus.s_awid = id; bus.s_awaddr = addr; bus.s_awlen = len; bus.s_awvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_awready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) note_fail("aw_handshake", "awready never seen");
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        bus.s_wdata = data; bus.s_wstrb = strb; bus.s_wlast = last; bus.s_wvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_wready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) note_fail("w_handshake", "wready never seen");
        @(posedge clk); #1;
        bus.s_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [8:0] id, input logic [17:0] addr, input logic [7:0] len);
        int n = 0;
        bus.s_arid = id; bus.s_araddr = addr; bus.s_arlen = len; bus.s_arvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_arready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) note_fail("ar_handshake", "arready never seen");
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((q_csr.size() + q_b.size() + q_r.size()) != 0 && n < budget) begin
            @(negedge clk); n++;
        end
        if ((q_csr.size() + q_b.size() + q_r.size()) != 0)
            note_fail(name, "expected responses still outstanding after cycle budget");
        @(posedge clk); #1;
    endtask

    task automatic exp_wr(input logic [17:0] a, input logic [63:0] d, input logic [7:0] s);
        q_csr.push_back('{wr: 1'b1, addr: a, data: d, strb: s});
    endtask
    task automatic exp_rd(input logic [17:0] a);
        q_csr.push_back('{wr: 1'b0, addr: a, data: 64'd0, strb: 8'd0});
    endtask
    task automatic exp_b(input logic [8:0] id, input logic [1:0] resp);
        q_b.push_back('{id: id, resp: resp});
    endtask
    task automatic exp_r(input logic [8:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
        q_r.push_back('{id: id, data: d, resp: resp, last: last});
    endtask

    // ---------------- CSR responder ----------------
    initial begin : responder
        int req_cyc = 0;
        bus.csr_ack = 1'b0; bus.csr_rdata = 64'd0; bus.csr_err = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.csr_wr || bus.csr_rd) req_cyc++;
            else                          req_cyc = 0;
            bus.csr_ack   = (ack_en && (bus.csr_wr || bus.csr_rd) && req_cyc == ack_delay) || late_ack;
            bus.csr_rdata = ack_rdata;
            bus.csr_err   = ack_err;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic p_wr = 1'b0, p_rd = 1'b0;
        logic p_bvalid = 1'b0, p_bready = 1'b0, p_rvalid = 1'b0, p_rready = 1'b0;
        logic [8:0]  p_bid = '0, p_rid = '0;
        logic [1:0]  p_bresp = '0, p_rresp = '0;
        logic [63:0] p_rdata = '0;
        logic        p_rlast = 1'b0;
        csr_t c; b_t b; r_t r;
        forever begin
            @(negedge clk);
            if ((bus.csr_wr && !p_wr) || (bus.csr_rd && !p_rd)) begin
                chk("csr_exclusive", {63'd0, bus.csr_wr & bus.csr_rd}, 64'd0);
                if (q_csr.size() == 0) note_fail("csr_unexpected", "CSR access with none expected");
                else begin
                    c = q_csr.pop_front();
                    chk("csr_kind", {63'd0, bus.csr_wr}, {63'd0, c.wr});
                    chk("csr_addr", {46'd0, bus.csr_addr}, {46'd0, c.addr});
                    if (c.wr) begin
                        chk("csr_wdata", bus.csr_wdata, c.data);
                        chk("csr_wstrb", {56'd0, bus.csr_wstrb}, {56'd0, c.strb});
                    end
                end
            end
            if (p_bvalid && !p_bready) begin
                chk("b_hold_valid", {63'd0, bus.s_bvalid}, 64'd1);
                chk("b_hold_id",    {55'd0, bus.s_bid},   {55'd0, p_bid});
                chk("b_hold_resp",  {62'd0, bus.s_bresp}, {62'd0, p_bresp});
            end
            if (p_rvalid && !p_rready) begin
                chk("r_hold_valid", {63'd0, bus.s_rvalid}, 64'd1);
                chk("r_hold_id",    {55'd0, bus.s_rid},   {55'd0, p_rid});
                chk("r_hold_data",  bus.s_rdata, p_rdata);
                chk("r_hold_last",  {63'd0, bus.s_rlast}, {63'd0, p_rlast});
            end
            if (bus.s_bvalid && bus.s_bready) begin
                if (q_b.size() == 0) note_fail("b_unexpected", "B response with none expected");
                else begin
                    b = q_b.pop_front();
                    chk("b_id",   {55'd0, bus.s_bid},   {55'd0, b.id});
                    chk("b_resp", {62'd0, bus.s_bresp}, {62'd0, b.resp});
                end
            end
            if (bus.s_rvalid && bus.s_rready) begin
                if (q_r.size() == 0) note_fail("r_unexpected", "R beat with none expected");
                else begin
                    r = q_r.pop_front();
                    chk("r_id",   {55'd0, bus.s_rid},   {55'd0, r.id});
                    chk("r_data", bus.s_rdata, r.data);
                    chk("r_resp", {62'd0, bus.s_rresp}, {62'd0, r.resp});
                    chk("r_last", {63'd0, bus.s_rlast}, {63'd0, r.last});
                end
            end
            p_wr = bus.csr_wr; p_rd = bus.csr_rd;
            p_bvalid = bus.s_bvalid; p_bready = bus.s_bready; p_bid = bus.s_bid; p_bresp = bus.s_bresp;
            p_rvalid = bus.s_rvalid; p_rready = bus.s_rready; p_rid = bus.s_rid;
            p_rresp = bus.s_rresp; p_rdata = bus.s_rdata; p_rlast = bus.s_rlast;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stimulus
        int n;
        bus.s_awvalid = 1'b0; bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0;
        bus.s_wvalid  = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 1'b0;
        bus.s_arvalid = 1'b0; bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0;
        bus.s_bready  = 1'b1; bus.s_rready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", {63'd0, bus.s_awready}, 64'd1);
        chk("rst_wready",  {63'd0, bus.s_wready},  64'd1);
        chk("rst_arready", {63'd0, bus.s_arready}, 64'd1);
        chk("rst_bvalid",  {63'd0, bus.s_bvalid},  64'd0);
        chk("rst_rvalid",  {63'd0, bus.s_rvalid},  64'd0);
        chk("rst_csr_wr",  {63'd0, bus.csr_wr},    64'd0);
        chk("rst_csr_rd",  {63'd0, bus.csr_rd},    64'd0);
        chk("rst_bresp",   {62'd0, bus.s_bresp},   64'd0);
        chk("rst_rresp",   {62'd0, bus.s_rresp},   64'd0);
        chk("rst_rdata",   bus.s_rdata,            64'd0);
        chk("rst_rlast",   {63'd0, bus.s_rlast},   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous write and read, twice: write wins each time
        ack_rdata = 64'hAAAA;
        exp_wr(18'h10, 64'h11, 8'hFF); exp_rd(18'h20);
        exp_b(9'd1, OKAY); exp_r(9'd2, 64'hAAAA, OKAY, 1'b1);
        fork
            send_aw(9'd1, 18'h10, 8'd0);
            send_w(64'h11, 8'hFF, 1'b1);
            send_ar(9'd2, 18'h20, 8'd0);
        join
        wait_idle("arb_round1", 50);
        ack_rdata = 64'hBBBB;
        exp_wr(18'h18, 64'h22, 8'h0F); exp_rd(18'h28);
        exp_b(9'd3, OKAY); exp_r(9'd4, 64'hBBBB, OKAY, 1'b1);
        fork
            send_aw(9'd3, 18'h18, 8'd0);
            send_w(64'h22, 8'h0F, 1'b1);
            send_ar(9'd4, 18'h28, 8'd0);
        join
        wait_idle("arb_round2", 50);

        // Single write, ack on the third request cycle
        ack_delay = 3;
        exp_wr(18'h100, 64'hDEAD_BEEF, 8'hFF); exp_b(9'd5, OKAY);
        fork
            send_aw(9'd5, 18'h100, 8'd0);
            send_w(64'hDEAD_BEEF, 8'hFF, 1'b1);
        join
        wait_idle("write_basic", 50);
        ack_delay = 1;

        // Single read
        ack_rdata = 64'h1234;
        exp_rd(18'h40); exp_r(9'd7, 64'h1234, OKAY, 1'b1);
        send_ar(9'd7, 18'h40, 8'd0);
        wait_idle("read_basic", 50);

        // W before AW
        exp_wr(18'h108, 64'h55, 8'h3C); exp_b(9'd6, OKAY);
        send_w(64'h55, 8'h3C, 1'b1);
        repeat (3) @(posedge clk); #1;
        send_aw(9'd6, 18'h108, 8'd0);
        wait_idle("w_before_aw", 50);

        // CSR error maps to SLVERR
        ack_err = 1'b1;
        exp_wr(18'h200, 64'h77, 8'h01); exp_b(9'd8, SLVERR);
        fork
            send_aw(9'd8, 18'h200, 8'd0);
            send_w(64'h77, 8'h01, 1'b1);
        join
        wait_idle("write_err", 50);
        ack_err = 1'b0;

        // Read burst arlen=3: four SLVERR beats, no CSR access
        for (int i = 0; i < 4; i++) exp_r(9'd9, 64'd0, SLVERR, (i == 3));
        send_ar(9'd9, 18'h300, 8'd3);
        wait_idle("read_burst", 50);

        // Write burst awlen=2: three beats drained, one SLVERR B
        exp_b(9'd10, SLVERR);
        fork
            send_aw(9'd10, 18'h308, 8'd2);
            begin
                send_w(64'hA0, 8'hFF, 1'b0);
                send_w(64'hA1, 8'hFF, 1'b0);
                send_w(64'hA2, 8'hFF, 1'b1);
            end
        join
        wait_idle("write_burst", 50);

        // B backpressure with a read waiting behind it
        bus.s_bready = 1'b0;
        ack_rdata = 64'h77;
        exp_wr(18'h400, 64'hCAFE, 8'hFF); exp_b(9'd11, OKAY);
        exp_rd(18'h48); exp_r(9'd12, 64'h77, OKAY, 1'b1);
        fork
            send_aw(9'd11, 18'h400, 8'd0);
            send_w(64'hCAFE, 8'hFF, 1'b1);
        join
        n = 0;
        while (!bus.s_bvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.s_bvalid) note_fail("b_backpressure_start", "bvalid never asserted");
        fork send_ar(9'd12, 18'h48, 8'd0); join_none
        repeat (10) begin
            @(negedge clk);
            chk("bp_bvalid", {63'd0, bus.s_bvalid}, 64'd1);
            chk("bp_no_csr", {62'd0, bus.csr_rd, bus.csr_wr}, 64'd0);
        end
        @(posedge clk); #1;
        bus.s_rready = 1'b0;
        bus.s_bready = 1'b1;
        n = 0;
        while (!bus.s_rvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.s_rvalid) note_fail("r_backpressure_start", "rvalid never asserted");
        repeat (10) begin
            @(negedge clk);
            chk("bp_rvalid", {63'd0, bus.s_rvalid}, 64'd1);
        end
        @(posedge clk); #1;
        bus.s_rready = 1'b1;
        wait_idle("backpressure", 50);

`ifdef OFS_FIM_MMIO_CSR_TIMEOUT_EN
        // No ack: timeout returns all-ones SLVERR, a late ack is ignored
        ack_en = 1'b0;
        exp_rd(18'h50); exp_r(9'd14, 64'hFFFF_FFFF_FFFF_FFFF, SLVERR, 1'b1);
        send_ar(9'd14, 18'h50, 8'd0);
        wait_idle("timeout_read", 600);
        late_ack = 1'b1;
        @(posedge clk); #1;
        late_ack = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("late_ack_no_resp", {62'd0, bus.s_bvalid, bus.s_rvalid}, 64'd0);
        end
        ack_en = 1'b1;
        ack_rdata = 64'h99;
        exp_rd(18'h58); exp_r(9'd16, 64'h99, OKAY, 1'b1);
        send_ar(9'd16, 18'h58, 8'd0);
        wait_idle("after_timeout", 50);
`endif

        // Reset while a write request is held
        ack_en = 1'b0;
        exp_wr(18'h500, 64'h5A5A, 8'hF0);
        fork
            send_aw(9'd15, 18'h500, 8'd0);
            send_w(64'h5A5A, 8'hF0, 1'b1);
        join
        n = 0;
        while (!bus.csr_wr && n < 50) begin @(negedge clk); n++; end
        if (!bus.csr_wr) note_fail("rst_mid_start", "csr_wr never asserted");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_csr_wr",  {63'd0, bus.csr_wr},    64'd0);
        chk("rst_mid_awready", {63'd0, bus.s_awready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("rst_mid_no_b", {63'd0, bus.s_bvalid}, 64'd0);
        end
        @(posedge clk); #1;
        wait_idle("final", 50);
        chk("final_csr_queue", q_csr.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
